dhcp_server: RTL and testbench

//  Minimal single-lease DHCP server (UDP port 67) for a radio cabled directly to a PC with no DHCP on the LAN.

---
 rtl/dhcp_pkg.sv | 40 ++++
 rtl/dhcp_opt_parser.sv | 102 ++++++++++
 rtl/dhcp_server.sv | 236 +++++++++++++++++++++++
 tb/tb_dhcp_server.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dhcp_pkg.sv
// Shared DHCP constants for the single-lease server: message types, option codes,
// magic cookie, UDP ports and reply lengths.
package dhcp_pkg;

    typedef enum logic [7:0] {
        DHCP_DISCOVER = 8'd1,
        DHCP_OFFER    = 8'd2,
        DHCP_REQUEST  = 8'd3,
        DHCP_ACK      = 8'd5,
        DHCP_NAK      = 8'd6
    } dhcp_msg_t;

    localparam logic [7:0] OPT_PAD          = 8'd0;
    localparam logic [7:0] OPT_SUBNET_MASK  = 8'd1;
    localparam logic [7:0] OPT_REQUESTED_IP = 8'd50;
    localparam logic [7:0] OPT_LEASE_TIME   = 8'd51;
    localparam logic [7:0] OPT_MSG_TYPE     = 8'd53;
    localparam logic [7:0] OPT_SERVER_ID    = 8'd54;
    localparam logic [7:0] OPT_END          = 8'd255;

    localparam logic [31:0] DHCP_MAGIC_COOKIE = 32'h63825363;
    localparam logic [15:0] DHCP_SERVER_PORT  = 16'd67;
    localparam logic [15:0] DHCP_CLIENT_PORT  = 16'd68;

    localparam logic [15:0] REPLY_LEN_FULL = 16'd262;
    localparam logic [15:0] REPLY_LEN_NAK  = 16'd250;
    localparam logic [15:0] COOKIE_OFFSET  = 16'd236;
    localparam logic [15:0] OPTIONS_OFFSET = 16'd240;

    // Byte k of a 32-bit word in network order (k=0 is the most significant byte).
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/dhcp_opt_parser.sv
// DHCP option TLV walker: consumes option bytes from offset 240 and extracts
// message type, requested IP and server identifier.
module dhcp_opt_parser
    import dhcp_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [7:0]  msg_type,
    output logic        msg_type_valid,
    output logic [31:0] req_ip,
    output logic        req_ip_valid,
    output logic [31:0] server_id,
    output logic        server_id_valid,
    output logic        parse_error
);

    localparam logic [1:0] P_CODE = 2'd0;
    localparam logic [1:0] P_LEN  = 2'd1;
    localparam logic [1:0] P_DATA = 2'd2;
    localparam logic [1:0] P_DONE = 2'd3;

    logic [1:0] state;
    logic [7:0] code;
    logic [7:0] remaining;
    logic [7:0] pos;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= P_CODE;
            code            <= '0;
            remaining       <= '0;
            pos             <= '0;
            msg_type        <= '0;
            msg_type_valid  <= 1'b0;
            req_ip          <= '0;
            req_ip_valid    <= 1'b0;
            server_id       <= '0;
            server_id_valid <= 1'b0;
        end else if (clear) begin
            state           <= P_CODE;
            code            <= '0;
            remaining       <= '0;
            pos             <= '0;
            msg_type        <= '0;
            msg_type_valid  <= 1'b0;
            req_ip          <= '0;
            req_ip_valid    <= 1'b0;
            server_id       <= '0;
            server_id_valid <= 1'b0;
        end else if (byte_valid) begin
            case (state)
                P_CODE: begin
                    if (byte_in == OPT_END) begin
                        state <= P_DONE;
                    end else if (byte_in != OPT_PAD) begin
                        code  <= byte_in;
                        state <= P_LEN;
                    end
                end
                P_LEN: begin
                    remaining <= byte_in;
                    pos       <= '0;
                    state     <= (byte_in == 8'd0) ? P_CODE : P_DATA;
                end
                P_DATA: begin
                    case (code)
                        OPT_MSG_TYPE: begin
                            if (pos == 8'd0) begin
                                msg_type       <= byte_in;
                                msg_type_valid <= 1'b1;
                            end
                        end
                        OPT_REQUESTED_IP: begin
                            if (pos < 8'd4) begin
                                req_ip <= {req_ip[23:0], byte_in};
                                if (pos == 8'd3) req_ip_valid <= 1'b1;
                            end
                        end
                        OPT_SERVER_ID: begin
                            if (pos < 8'd4) begin
                                server_id <= {server_id[23:0], byte_in};
                                if (pos == 8'd3) server_id_valid <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                    pos       <= pos + 8'd1;
                    remaining <= remaining - 8'd1;
                    if (remaining == 8'd1) state <= P_CODE;
                end
                default: ;
            endcase
        end
    end

    // Payload ending between a code byte and the last data byte means a truncated option.
    assign parse_error = (state == P_LEN) || (state == P_DATA);

endmodule

// File: rtl/dhcp_server.sv
// Minimal single-lease DHCP server: parses DISCOVER/REQUEST payloads and answers
// with OFFER, ACK or NAK built byte-by-byte for the UDP transmit arbiter.
module dhcp_server
    import dhcp_pkg::*;
#(
    parameter logic [31:0] LEASE_SECONDS = 32'd3600,
    parameter logic [31:0] SUBNET_MASK   = 32'hFFFFFF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  rx_data,
    input  logic        rx_enable,
    input  logic        dhcp_rx_active,
    input  logic        udp_tx_enable,
    input  logic        udp_tx_active,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [31:0] offer_ip,
    output logic        dhcp_tx_request,
    output logic [7:0]  tx_data,
    output logic [15:0] length,
    output logic [47:0] dhcp_destination_mac,
    output logic [31:0] dhcp_destination_ip,
    output logic [15:0] dhcp_destination_port,
    output logic [47:0] client_mac,
    output logic        client_bound
);

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_REQ  = 2'd1;
    localparam logic [1:0] TX_SEND = 2'd2;

    assign dhcp_destination_mac  = 48'hFFFFFFFFFFFF;
    assign dhcp_destination_ip   = 32'hFFFFFFFF;
    assign dhcp_destination_port = DHCP_CLIENT_PORT;

    // Our MAC is only needed by the UDP/Ethernet layers, never inside the payload.
    logic unused_local_mac;
    assign unused_local_mac = ^local_mac;

    logic        rx_seen;
    logic [15:0] rx_idx;
    logic [7:0]  op, htype, hlen;
    logic [31:0] xid, ciaddr;
    logic [47:0] chaddr;
    logic        cookie_ok;

    logic        rx_accept, decide, parser_clear;
    logic [7:0]  msg_type;
    logic        msg_type_valid, req_ip_valid, server_id_valid, parse_error;
    logic [31:0] req_ip, server_id;

    assign rx_accept    = enable && dhcp_rx_active && rx_enable;
    assign decide       = enable && rx_seen && !dhcp_rx_active;
    assign parser_clear = !enable || (rx_seen && !dhcp_rx_active);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_seen   <= 1'b0;
            rx_idx    <= '0;
            op        <= '0;
            htype     <= '0;
            hlen      <= '0;
            xid       <= '0;
            ciaddr    <= '0;
            chaddr    <= '0;
            cookie_ok <= 1'b1;
        end else if (!enable) begin
            rx_seen   <= 1'b0;
            rx_idx    <= '0;
            cookie_ok <= 1'b1;
        end else if (dhcp_rx_active) begin
            rx_seen <= 1'b1;
            if (rx_enable) begin
                if (rx_idx == 16'd0) op    <= rx_data;
                if (rx_idx == 16'd1) htype <= rx_data;
                if (rx_idx == 16'd2) hlen  <= rx_data;
                if (rx_idx >= 16'd4 && rx_idx <= 16'd7)
                    xid <= {xid[23:0], rx_data};
                if (rx_idx >= 16'd12 && rx_idx <= 16'd15)
                    ciaddr <= {ciaddr[23:0], rx_data};
                if (rx_idx >= 16'd28 && rx_idx <= 16'd33)
                    chaddr <= {chaddr[39:0], rx_data};
                if (rx_idx >= COOKIE_OFFSET && rx_idx < OPTIONS_OFFSET &&
                    rx_data != word_byte(DHCP_MAGIC_COOKIE, rx_idx[1:0]))
                    cookie_ok <= 1'b0;
                if (rx_idx != '1) rx_idx <= rx_idx + 16'd1;
            end
        end else if (rx_seen) begin
            rx_seen   <= 1'b0;
            rx_idx    <= '0;
            cookie_ok <= 1'b1;
        end
    end

    dhcp_opt_parser u_opt_parser (
        .clock           (clock),
        .reset           (reset),
        .clear           (parser_clear),
        .byte_valid      (rx_accept && (rx_idx >= OPTIONS_OFFSET)),
        .byte_in         (rx_data),
        .msg_type        (msg_type),
        .msg_type_valid  (msg_type_valid),
        .req_ip          (req_ip),
        .req_ip_valid    (req_ip_valid),
        .server_id       (server_id),
        .server_id_valid (server_id_valid),
        .parse_error     (parse_error)
    );

    logic [1:0]  tx_state;
    logic [15:0] tx_idx;
    dhcp_msg_t   reply_type;
    logic [31:0] xid_q;
    logic [47:0] chaddr_q;

    logic        header_ok, start_reply;
    logic [31:0] req_addr;
    dhcp_msg_t   next_type;

    always_comb begin
        header_ok = (rx_idx >= OPTIONS_OFFSET) && (op == 8'd1) && (htype == 8'd1) &&
                    (hlen == 8'd6) && cookie_ok && msg_type_valid && !parse_error;
        req_addr    = req_ip_valid ? req_ip : ciaddr;
        start_reply = 1'b0;
        next_type   = DHCP_OFFER;
        if (decide && header_ok && tx_state == TX_IDLE) begin
            if (msg_type == DHCP_DISCOVER) begin
                start_reply = 1'b1;
                next_type   = DHCP_OFFER;
            end else if (msg_type == DHCP_REQUEST &&
                         !(server_id_valid && server_id != local_ip)) begin
                start_reply = 1'b1;
                next_type   = (req_addr == offer_ip) ? DHCP_ACK : DHCP_NAK;
            end
        end
    end

    logic [7:0]  reply_byte;
    logic        full_reply;
    logic [31:0] yiaddr;

    always_comb begin
        reply_byte = '0;
        full_reply = (reply_type != DHCP_NAK);
        yiaddr     = full_reply ? offer_ip : '0;
        if (tx_idx == 16'd0)      reply_byte = 8'h02;
        else if (tx_idx == 16'd1) reply_byte = 8'h01;
        else if (tx_idx == 16'd2) reply_byte = 8'h06;
        else if (tx_idx >= 16'd4 && tx_idx <= 16'd7)
            reply_byte = word_byte(xid_q, tx_idx[1:0]);
        else if (tx_idx >= 16'd16 && tx_idx <= 16'd19)
            reply_byte = word_byte(yiaddr, tx_idx[1:0]);
        else if (tx_idx >= 16'd20 && tx_idx <= 16'd23)
            reply_byte = word_byte(local_ip, tx_idx[1:0]);
        else if (tx_idx == 16'd28) reply_byte = chaddr_q[47:40];
        else if (tx_idx == 16'd29) reply_byte = chaddr_q[39:32];
        else if (tx_idx == 16'd30) reply_byte = chaddr_q[31:24];
        else if (tx_idx == 16'd31) reply_byte = chaddr_q[23:16];
        else if (tx_idx == 16'd32) reply_byte = chaddr_q[15:8];
        else if (tx_idx == 16'd33) reply_byte = chaddr_q[7:0];
        else if (tx_idx >= COOKIE_OFFSET && tx_idx < OPTIONS_OFFSET)
            reply_byte = word_byte(DHCP_MAGIC_COOKIE, tx_idx[1:0]);
        else if (tx_idx == 16'd240) reply_byte = OPT_MSG_TYPE;
        else if (tx_idx == 16'd241) reply_byte = 8'd1;
        else if (tx_idx == 16'd242) reply_byte = reply_type;
        else if (tx_idx == 16'd243) reply_byte = OPT_SERVER_ID;
        else if (tx_idx == 16'd244) reply_byte = 8'd4;
        // Option words sit off 4-byte alignment, so the byte lane is re-based per field.
        else if (tx_idx >= 16'd245 && tx_idx <= 16'd248)
            reply_byte = word_byte(local_ip, tx_idx[1:0] - 2'd1);
        else if (tx_idx == 16'd249) reply_byte = full_reply ? OPT_LEASE_TIME : OPT_END;
        else if (tx_idx == 16'd250) reply_byte = 8'd4;
        else if (tx_idx >= 16'd251 && tx_idx <= 16'd254)
            reply_byte = word_byte(LEASE_SECONDS, tx_idx[1:0] + 2'd1);
        else if (tx_idx == 16'd255) reply_byte = OPT_SUBNET_MASK;
        else if (tx_idx == 16'd256) reply_byte = 8'd4;
        else if (tx_idx >= 16'd257 && tx_idx <= 16'd260)
            reply_byte = word_byte(SUBNET_MASK, tx_idx[1:0] - 2'd1);
        else if (tx_idx == 16'd261) reply_byte = OPT_END;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state        <= TX_IDLE;
            tx_idx          <= '0;
            reply_type      <= DHCP_OFFER;
            xid_q           <= '0;
            chaddr_q        <= '0;
            dhcp_tx_request <= 1'b0;
            tx_data         <= '0;
            length          <= '0;
            client_mac      <= '0;
            client_bound    <= 1'b0;
        end else begin
            client_bound <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (start_reply) begin
                        reply_type      <= next_type;
                        xid_q           <= xid;
                        chaddr_q        <= chaddr;
                        tx_idx          <= '0;
                        length          <= (next_type == DHCP_NAK) ? REPLY_LEN_NAK : REPLY_LEN_FULL;
                        dhcp_tx_request <= 1'b1;
                        tx_state        <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    if (udp_tx_enable) begin
                        tx_data  <= reply_byte;
                        tx_idx   <= 16'd1;
                        tx_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (udp_tx_active) begin
                        tx_data <= reply_byte;
                        tx_idx  <= tx_idx + 16'd1;
                        if (tx_idx == length - 16'd1) begin
                            dhcp_tx_request <= 1'b0;
                            tx_state        <= TX_IDLE;
                            if (reply_type == DHCP_ACK) begin
                                client_mac   <= chaddr_q;
                                client_bound <= 1'b1;
                            end
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dhcp_server.sv
// Directed bench for dhcp_server: builds DHCP payloads, drives the grant/consume
// handshake and compares each reply against an independently built reference reply.
module tb_dhcp_server;

    localparam logic [31:0] LOCAL_IP  = 32'hC0A80101;
    localparam logic [31:0] OFFER_IP  = 32'hC0A80164;
    localparam logic [47:0] LOCAL_MAC = 48'h020000000001;
    localparam logic [47:0] MAC1      = 48'h001CC0A213DD;
    localparam logic [47:0] MAC2      = 48'h0A0B0C0D0E0F;

    logic        clock = 1'b0;
    logic        reset, enable, rx_enable, dhcp_rx_active, udp_tx_enable, udp_tx_active;
    logic [7:0]  rx_data;
    logic        dhcp_tx_request, client_bound;
    logic [7:0]  tx_data;
    logic [15:0] length, dhcp_destination_port;
    logic [47:0] dhcp_destination_mac, client_mac;
    logic [31:0] dhcp_destination_ip;

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned bound_count = 0;
    int unsigned nrecv;

    logic [7:0]  pkt   [0:511];
    int unsigned plen;
    logic [7:0]  exp_b [0:299];
    int unsigned elen;
    logic [7:0]  got   [0:299];

    always #5 clock = ~clock;

    dhcp_server #(
        .LEASE_SECONDS (32'd3600),
        .SUBNET_MASK   (32'hFFFFFF00)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .enable                (enable),
        .rx_data               (rx_data),
        .rx_enable             (rx_enable),
        .dhcp_rx_active        (dhcp_rx_active),
        .udp_tx_enable         (udp_tx_enable),
        .udp_tx_active         (udp_tx_active),
        .local_mac             (LOCAL_MAC),
        .local_ip              (LOCAL_IP),
        .offer_ip              (OFFER_IP),
        .dhcp_tx_request       (dhcp_tx_request),
        .tx_data               (tx_data),
        .length                (length),
        .dhcp_destination_mac  (dhcp_destination_mac),
        .dhcp_destination_ip   (dhcp_destination_ip),
        .dhcp_destination_port (dhcp_destination_port),
        .client_mac            (client_mac),
        .client_bound          (client_bound)
    );

    always @(negedge clock) if (client_bound) bound_count++;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic add_byte(input logic [7:0] b);
        pkt[plen] = b;
        plen++;
    endtask

    task automatic add4(input logic [31:0] w);
        add_byte(w[31:24]); add_byte(w[23:16]); add_byte(w[15:8]); add_byte(w[7:0]);
    endtask

    task automatic start_pkt(input logic [7:0] op_b, input logic [31:0] xid_b,
                             input logic [31:0] ci, input logic [47:0] mac, input bit bad_cookie);
        for (int i = 0; i < 240; i++) pkt[i] = 8'h00;
        pkt[0] = op_b; pkt[1] = 8'h01; pkt[2] = 8'h06;
        pkt[4] = xid_b[31:24]; pkt[5] = xid_b[23:16]; pkt[6] = xid_b[15:8]; pkt[7] = xid_b[7:0];
        pkt[12] = ci[31:24]; pkt[13] = ci[23:16]; pkt[14] = ci[15:8]; pkt[15] = ci[7:0];
        pkt[28] = mac[47:40]; pkt[29] = mac[39:32]; pkt[30] = mac[31:24];
        pkt[31] = mac[23:16]; pkt[32] = mac[15:8];  pkt[33] = mac[7:0];
        pkt[236] = 8'h63; pkt[237] = 8'h82; pkt[238] = 8'h53;
        pkt[239] = bad_cookie ? 8'h64 : 8'h63;
        plen = 240;
    endtask

    task automatic send_pkt(input bit stalls);
        for (int i = 0; i < int'(plen); i++) begin
            if (stalls && (i % 9 == 4)) begin
                dhcp_rx_active = 1'b1; rx_enable = 1'b0; rx_data = 8'hAA;
                tick();
            end
            dhcp_rx_active = 1'b1; rx_enable = 1'b1; rx_data = pkt[i];
            tick();
        end
        dhcp_rx_active = 1'b0; rx_enable = 1'b0; rx_data = 8'h00;
    endtask

    task automatic expect_req(input string tag, input logic [15:0] len);
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (dhcp_tx_request) seen = 1'b1;
        end
        check({tag, "_req"}, 64'(seen), 64'd1);
        check({tag, "_len"}, 64'(length), 64'(len));
    endtask

    task automatic expect_no_req(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dhcp_tx_request) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    // Grant after grant_delay cycles, then consume bytes (optionally with gaps) until stop_at bytes.
    task automatic receive(input int unsigned grant_delay, input bit gaps, input int unsigned stop_at);
        int unsigned cyc = 0;
        udp_tx_enable = 1'b0;
        for (int i = 0; i < int'(grant_delay); i++) tick();
        if (grant_delay > 0) check("req_held_ungranted", 64'(dhcp_tx_request), 64'd1);
        udp_tx_enable = 1'b1;
        tick();
        udp_tx_enable = 1'b0;
        nrecv = 0;
        while (nrecv < stop_at && cyc < 2000) begin
            cyc++;
            if (gaps && (cyc % 5 == 3)) begin
                udp_tx_active = 1'b0;
            end else begin
                udp_tx_active = 1'b1;
                got[nrecv] = tx_data;
                nrecv++;
            end
            tick();
        end
        udp_tx_active = 1'b0;
        if (nrecv < stop_at) check("receive_timeout", 64'(nrecv), 64'(stop_at));
    endtask

    task automatic set4(input int unsigned at, input logic [31:0] w);
        exp_b[at] = w[31:24]; exp_b[at+1] = w[23:16]; exp_b[at+2] = w[15:8]; exp_b[at+3] = w[7:0];
    endtask

    task automatic build_exp(input logic [7:0] t, input logic [31:0] xid_b, input logic [47:0] mac);
        bit full = (t != 8'd6);
        for (int i = 0; i < 300; i++) exp_b[i] = 8'h00;
        exp_b[0] = 8'h02; exp_b[1] = 8'h01; exp_b[2] = 8'h06;
        set4(4, xid_b);
        set4(16, full ? OFFER_IP : 32'h0);
        set4(20, LOCAL_IP);
        exp_b[28] = mac[47:40]; exp_b[29] = mac[39:32]; exp_b[30] = mac[31:24];
        exp_b[31] = mac[23:16]; exp_b[32] = mac[15:8];  exp_b[33] = mac[7:0];
        set4(236, 32'h63825363);
        exp_b[240] = 8'd53; exp_b[241] = 8'd1; exp_b[242] = t;
        exp_b[243] = 8'd54; exp_b[244] = 8'd4;
        set4(245, LOCAL_IP);
        if (full) begin
            exp_b[249] = 8'd51; exp_b[250] = 8'd4; set4(251, 32'd3600);
            exp_b[255] = 8'd1;  exp_b[256] = 8'd4; set4(257, 32'hFFFFFF00);
            exp_b[261] = 8'hFF;
            elen = 262;
        end else begin
            exp_b[249] = 8'hFF;
            elen = 250;
        end
    endtask

    task automatic compare_reply(input string tag);
        int unsigned mism = 0;
        for (int i = 0; i < int'(elen); i++) if (got[i] !== exp_b[i]) mism++;
        check(tag, 64'(mism), 64'd0);
    endtask

    task automatic request_pkt(input logic [31:0] xid_b, input logic [47:0] mac,
                               input logic [31:0] req, input logic [31:0] sid);
        start_pkt(8'h01, xid_b, 32'h0, mac, 1'b0);
        add_byte(8'd53); add_byte(8'd1); add_byte(8'd3);
        add_byte(8'd50); add_byte(8'd4); add4(req);
        add_byte(8'd54); add_byte(8'd4); add4(sid);
        add_byte(8'hFF);
    endtask

    task automatic discover_pkt(input logic [31:0] xid_b, input logic [47:0] mac);
        start_pkt(8'h01, xid_b, 32'h0, mac, 1'b0);
        add_byte(8'd53); add_byte(8'd1); add_byte(8'd1);
        add_byte(8'hFF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; rx_enable = 1'b0; dhcp_rx_active = 1'b0;
        udp_tx_enable = 1'b0; udp_tx_active = 1'b0; rx_data = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_request", 64'(dhcp_tx_request), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_length", 64'(length), 64'd0);
        check("rst_client_mac", 64'(client_mac), 64'd0);
        check("rst_client_bound", 64'(client_bound), 64'd0);
        check("const_dest", {dhcp_destination_ip, dhcp_destination_port, 16'h0}, 64'hFFFFFFFF_0044_0000);
        check("const_dest_mac", 64'(dhcp_destination_mac), 64'hFFFFFFFFFFFF);

        // DISCOVER -> OFFER
        discover_pkt(32'h12345678, MAC1);
        send_pkt(1'b0);
        expect_req("t1", 16'd262);
        receive(0, 1'b0, 262);
        build_exp(8'd2, 32'h12345678, MAC1);
        compare_reply("t1_bytes");
        check("t1_byte0", 64'(got[0]), 64'h02);
        check("t1_xid", {32'h0, got[4], got[5], got[6], got[7]}, 64'h12345678);
        check("t1_yiaddr", {32'h0, got[16], got[17], got[18], got[19]}, 64'hC0A80164);
        check("t1_opt53", {40'h0, got[240], got[241], got[242]}, 64'h350102);
        check("t1_end", 64'(got[261]), 64'hFF);
        check("t1_req_done", 64'(dhcp_tx_request), 64'd0);
        check("t1_no_bound", 64'(bound_count), 64'd0);

        // REQUEST for the offered address naming us -> ACK
        request_pkt(32'h12345679, MAC1, OFFER_IP, LOCAL_IP);
        send_pkt(1'b0);
        expect_req("t2", 16'd262);
        receive(0, 1'b0, 262);
        build_exp(8'd5, 32'h12345679, MAC1);
        compare_reply("t2_bytes");
        check("t2_opt53", {40'h0, got[240], got[241], got[242]}, 64'h350105);
        check("t2_lease", {32'h0, got[251], got[252], got[253], got[254]}, 64'h00000E10);
        tick();
        check("t2_bound", 64'(bound_count), 64'd1);
        check("t2_client_mac", 64'(client_mac), 64'(MAC1));

        // REQUEST for another address -> NAK; REQUEST naming another server -> ignored
        request_pkt(32'h0000BEEF, MAC2, 32'hC0A80165, LOCAL_IP);
        send_pkt(1'b0);
        expect_req("t3_nak", 16'd250);
        receive(0, 1'b0, 250);
        build_exp(8'd6, 32'h0000BEEF, MAC2);
        compare_reply("t3_nak_bytes");
        check("t3_yiaddr", {32'h0, got[16], got[17], got[18], got[19]}, 64'h0);
        check("t3_end", 64'(got[249]), 64'hFF);
        tick();
        check("t3_no_bound", 64'(bound_count), 64'd1);
        request_pkt(32'h0000BEF0, MAC2, OFFER_IP, 32'hC0A80102);
        send_pkt(1'b0);
        expect_no_req("t3_other_server");

        // Pads, unknown option, opt 53 last, with rx_enable stalls -> OFFER
        start_pkt(8'h01, 32'hCAFEF00D, 32'h0, MAC2, 1'b0);
        add_byte(8'h00); add_byte(8'h00);
        add_byte(8'd12); add_byte(8'd10);
        for (int i = 0; i < 10; i++) add_byte(8'h41 + 8'(i));
        add_byte(8'h00);
        add_byte(8'd53); add_byte(8'd1); add_byte(8'd1);
        add_byte(8'hFF);
        send_pkt(1'b1);
        expect_req("t4", 16'd262);
        receive(0, 1'b0, 262);
        build_exp(8'd2, 32'hCAFEF00D, MAC2);
        compare_reply("t4_bytes");

        start_pkt(8'h01, 32'h1, 32'h0, MAC2, 1'b1);
        add_byte(8'd53); add_byte(8'd1); add_byte(8'd1); add_byte(8'hFF);
        send_pkt(1'b0);
        expect_no_req("t4_bad_cookie");

        start_pkt(8'h02, 32'h2, 32'h0, MAC2, 1'b0);
        add_byte(8'd53); add_byte(8'd1); add_byte(8'd1); add_byte(8'hFF);
        send_pkt(1'b0);
        expect_no_req("t4_op2");

        start_pkt(8'h01, 32'h3, 32'h0, MAC2, 1'b0);
        add_byte(8'd53); add_byte(8'd1); add_byte(8'd1);
        add_byte(8'd12); add_byte(8'd8); add_byte(8'h78); add_byte(8'h78);
        send_pkt(1'b0);
        expect_no_req("t4_truncated_opt");

        start_pkt(8'h01, 32'h4, 32'h0, MAC2, 1'b0);
        plen = 100;
        send_pkt(1'b0);
        expect_no_req("t4_short");

        enable = 1'b0;
        discover_pkt(32'h5, MAC2);
        send_pkt(1'b0);
        expect_no_req("t4_disabled");
        enable = 1'b1;
        tick();

        // Delayed grant with consume gaps; a DISCOVER arriving mid-send is dropped
        discover_pkt(32'hAABBCCDD, MAC1);
        send_pkt(1'b0);
        expect_req("t5", 16'd262);
        build_exp(8'd2, 32'hAABBCCDD, MAC1);
        discover_pkt(32'h55555555, MAC2);
        fork
            receive(50, 1'b1, 262);
            begin
                repeat (70) tick();
                send_pkt(1'b0);
            end
        join
        compare_reply("t5_bytes");
        check("t5_count", 64'(nrecv), 64'd262);
        expect_no_req("t5_second_dropped");

        // Reset at byte 100 of an ACK
        request_pkt(32'h00C0FFEE, MAC2, OFFER_IP, LOCAL_IP);
        send_pkt(1'b0);
        expect_req("t6", 16'd262);
        receive(0, 1'b0, 100);
        reset = 1'b1;
        tick();
        check("t6_req_dropped", 64'(dhcp_tx_request), 64'd0);
        reset = 1'b0;
        repeat (5) tick();
        check("t6_no_bound", 64'(bound_count), 64'd1);
        check("t6_client_mac", 64'(client_mac), 64'd0);
        discover_pkt(32'h0BADCAFE, MAC1);
        send_pkt(1'b0);
        expect_req("t6_after", 16'd262);
        receive(0, 1'b1, 262);
        build_exp(8'd2, 32'h0BADCAFE, MAC1);
        compare_reply("t6_after_bytes");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
